bram_byte_writer: RTL

//   Stream-fed byte writer into one RAMB18E2 (port B write, port A read), so a ROM-style

---
 rtl/bram_byte_writer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bram_byte_writer.sv
// -----------------------------------------------------------------------------
// bram_byte_writer
//
// Loads a byte-wide lookup table at run time. A start command captures a base
// address and a length. The block then takes bytes from a valid/ready stream
// and writes them to consecutive addresses, wrapping past the top of the table.
// A separate read port with one cycle of latency serves the consumer logic.
//
// The storage is written so that it maps onto a single RAMB18E2 in x9 mode.
// Port B is the write port, addressed by the internal pointer. Port A is the
// read port: it has no output register, and its output latch is cleared by
// reset. BRAM_LOC names the site that the placement constraints pin the RAM to.
//
// Parameters
//   ADDR_W     byte address width, 1..11 (2048 entries at most)
//   BRAM_LOC   placement site of the RAM
//
// Ports
//   clock      single clock for both RAM ports
//   reset      synchronous, active-high
//   start      command strobe, sampled only while idle
//   base_addr  first write address, captured on an accepted start
//   len        byte count 0..2^ADDR_W; larger values are clamped
//   in_valid   stream byte valid
//   in_ready   stream byte ready (high while writing)
//   in_data    stream byte
//   busy       high while writing
//   done       one-cycle pulse when a command completes
//   rd_addr    read address
//   rd_data    read data, valid the cycle after rd_addr
// -----------------------------------------------------------------------------
module bram_byte_writer #(
    parameter int ADDR_W   = 8,
    parameter     BRAM_LOC = "RAMB18_X0Y3"
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int            depth   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] max_len = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] one     = {{ADDR_W{1'b0}}, 1'b1};

    // Refuse to elaborate for widths the RAM cannot hold or without a site.
    if (ADDR_W < 1 || ADDR_W > 11 || BRAM_LOC == "") begin : g_bad_param
        $error("bram_byte_writer: ADDR_W must be 1..11 and BRAM_LOC non-empty");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     rem_q;
    logic                xfer;
    logic                wr_en;
    logic [7:0]          rd_q;

    (* ram_style = "block" *)
    logic [7:0]          mem [depth];

    assign xfer  = in_valid & in_ready;
    // The byte presented on the reset edge must not land in the table.
    assign wr_en = xfer & ~reset;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // The transfer that consumes the last remaining byte ends the command.
                if (in_valid && rem_q == one) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Write pointer and remaining count
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else if (state_q == IDLE && start) begin
            ptr_q <= base_addr;
            rem_q <= (len > max_len) ? max_len : len;
        end else if (xfer) begin
            // Pointer width equals the address width, so it wraps past the top.
            ptr_q <= ptr_q + 1'b1;
            rem_q <= rem_q - one;
        end
    end

    // -------------------------------------------------------------------------
    // Storage: port B write
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset; block RAM contents cannot be cleared by a
    // reset, and the table must survive a reset anyway.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[ptr_q] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Storage: port A read, one cycle latency, output latch cleared by reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= 8'h00;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_q;

endmodule
